const_bits_monitor: RTL and testbench

CONST_BITS_MONITOR -- requirements
Module: const_bits_monitor

---
 rtl/const_bits_monitor.sv | 106 ++++++++++
 tb/tb_const_bits_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/const_bits_monitor.sv
// const_bits_monitor: watches a bus for a constant value, locks after
// LOCK_COUNT consecutive valid matches, and latches a sticky fault when a
// locked bus deviates. Saturating counters track matching/non-matching samples.
module const_bits_monitor #(
    parameter int unsigned       WIDTH      = 2,
    parameter logic [WIDTH-1:0]  VALUE      = 2'h1,
    parameter int unsigned       LOCK_COUNT = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [1:0]       state,
    output logic [7:0]       match_count,
    output logic [7:0]       mismatch_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [4:0] LOCK_TGT = 5'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [7:0] match_q, match_d;
    logic [7:0] mismatch_q, mismatch_d;

    logic       sample_match;
    logic [4:0] run_inc;

    assign sample_match = (I == VALUE);
    assign run_inc      = {1'b0, run_q} + 5'd1;

    // Next-state, run counter and saturating sample counters.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;
        if (clear) begin
            state_d    = ST_ACQUIRE;
            run_d      = '0;
            match_d    = '0;
            mismatch_d = '0;
        end else if (I_valid) begin
            if (sample_match) begin
                if (match_q != 8'hFF) match_d = match_q + 8'd1;
            end else begin
                if (mismatch_q != 8'hFF) mismatch_d = mismatch_q + 8'd1;
            end
            unique case (state_q)
                // IDLE treats its first sample exactly like an ACQUIRE sample.
                ST_IDLE, ST_ACQUIRE: begin
                    if (sample_match) begin
                        if (run_inc == LOCK_TGT) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            run_d   = run_inc[3:0];
                        end
                    end else begin
                        state_d = ST_ACQUIRE;
                        run_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!sample_match) state_d = ST_FAULT;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign state          = state_q;
    assign locked         = (state_q == ST_LOCKED);
    assign error          = (state_q == ST_FAULT);
    assign match_count    = match_q;
    assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_const_bits_monitor.sv
// Directed self-checking bench for const_bits_monitor (default parameters).
module tb_const_bits_monitor;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b1;
    logic [1:0] I = 2'h0;
    logic       I_valid = 1'b0;
    logic       clear = 1'b0;
    logic       locked;
    logic       error;
    logic [1:0] state;
    logic [7:0] match_count;
    logic [7:0] mismatch_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    const_bits_monitor #(
        .WIDTH(2),
        .VALUE(2'h1),
        .LOCK_COUNT(4)
    ) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .I(I),
        .I_valid(I_valid),
        .clear(clear),
        .locked(locked),
        .error(error),
        .state(state),
        .match_count(match_count),
        .mismatch_count(mismatch_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Apply one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic step(input logic v, input logic [1:0] d, input logic c);
        @(negedge CLK);
        I_valid = v;
        I       = d;
        clear   = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic lk,
                             input logic er, input logic [7:0] mc, input logic [7:0] mm);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".locked"}, 32'(locked), 32'(lk));
        check({tag, ".error"}, 32'(error), 32'(er));
        check({tag, ".match"}, 32'(match_count), 32'(mc));
        check({tag, ".mismatch"}, 32'(mismatch_count), 32'(mm));
    endtask

    initial begin
        logic [1:0] seq_i [8];
        logic [1:0] seq_st [8];

        // Reset state
        #12;
        check_all("reset", 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        // Four matches lock: state 1,1,1,2
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'h1, 1'b0);
            check($sformatf("lock4.st%0d", k), 32'(state), (k == 3) ? 32'd2 : 32'd1);
        end
        check_all("lock4", 2'd2, 1'b1, 1'b0, 8'd4, 8'd0);

        // Mismatch while locked faults; fault is sticky
        step(1'b1, 2'h3, 1'b0);
        check_all("fault", 2'd3, 1'b0, 1'b1, 8'd4, 8'd1);
        step(1'b1, 2'h1, 1'b0);
        step(1'b1, 2'h1, 1'b0);
        check_all("sticky", 2'd3, 1'b0, 1'b1, 8'd6, 8'd1);
        step(1'b0, 2'h1, 1'b1);
        check_all("clear", 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);

        // Interrupted run: lock only on the 8th sample
        seq_i  = '{2'h1, 2'h1, 2'h1, 2'h2, 2'h1, 2'h1, 2'h1, 2'h1};
        seq_st = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int k = 0; k < 8; k++) begin
            step(1'b1, seq_i[k], 1'b0);
            check($sformatf("rerun.st%0d", k), 32'(state), 32'(seq_st[k]));
            check($sformatf("rerun.err%0d", k), 32'(error), 32'd0);
        end
        check_all("rerun", 2'd2, 1'b1, 1'b0, 8'd7, 8'd1);

        // Invalid cycles change nothing
        step(1'b0, 2'h3, 1'b0);
        step(1'b0, 2'h1, 1'b0);
        check_all("novalid", 2'd2, 1'b1, 1'b0, 8'd7, 8'd1);

        // Clear beats a concurrent mismatch while locked
        step(1'b1, 2'h3, 1'b1);
        check_all("clr_prio", 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);

        // Saturation at 255
        for (int k = 0; k < 254; k++) step(1'b1, 2'h1, 1'b0);
        check("sat.254", 32'(match_count), 32'd254);
        step(1'b1, 2'h1, 1'b0);
        check("sat.255", 32'(match_count), 32'd255);
        for (int k = 0; k < 45; k++) step(1'b1, 2'h1, 1'b0);
        check_all("sat300", 2'd2, 1'b1, 1'b0, 8'd255, 8'd0);
        step(1'b0, 2'h2, 1'b0);
        check_all("sat_novalid", 2'd2, 1'b1, 1'b0, 8'd255, 8'd0);

        // Async reset between edges while in FAULT
        step(1'b1, 2'h0, 1'b0);
        check_all("fault2", 2'd3, 1'b0, 1'b1, 8'd255, 8'd1);
        I_valid = 1'b0;
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_all("async_rst", 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Release honoured on the next edge; that sample is processed
        step(1'b1, 2'h1, 1'b0);
        check_all("held_rst", 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(posedge CLK);
        #1;
        check_all("release", 2'd1, 1'b0, 1'b0, 8'd1, 8'd0);

        // Mismatch in ACQUIRE restarts the run without faulting
        step(1'b1, 2'h1, 1'b0);
        step(1'b1, 2'h1, 1'b0);
        step(1'b1, 2'h0, 1'b0);
        check_all("acq_mis", 2'd1, 1'b0, 1'b0, 8'd3, 8'd1);
        step(1'b1, 2'h1, 1'b0);
        check("acq_mis.nolock", 32'(state), 32'd1);

        // Mismatch as first sample out of IDLE still counts
        @(negedge CLK);
        ASYNCRESET = 1'b1;
        #1;
        ASYNCRESET = 1'b0;
        I_valid = 1'b1;
        I = 2'h2;
        @(posedge CLK);
        #1;
        check_all("idle_mis", 2'd1, 1'b0, 1'b0, 8'd0, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
